// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - multi-cycle chunked two's-complement adder/subtractor
//
// Purpose : adds (mode=0) or subtracts (mode=1) two WIDTH-bit operands CHUNK bits per
//           clock through a single ripple slice, LSB chunk first, with the inter-chunk
//           carry held in a register. Reports carry/borrow and signed overflow.
// Params  : WIDTH - operand/result width (integer multiple of CHUNK)
//           CHUNK - bits processed per clock; N = WIDTH/CHUNK cycles per operation
// Ports   : clk    - clock, rising edge
//           rst    - asynchronous active-high reset
//           start  - request, sampled only in IDLE
//           a, b   - operands, sampled with start
//           mode   - 0 = add, 1 = subtract, sampled with start
//           busy   - high while the chunks are being processed
//           done   - one-cycle pulse, result/cout/ovf valid
//           result - registered sum/difference
//           cout   - carry out of MSB (subtract: 1 = no borrow)
//           ovf    - signed overflow
// Config  : ADDSUB_SAT_EN - when defined, result saturates on signed overflow
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             a_sign_q, a_sign_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK:0]   slice_sum;
    logic             msb_cin;
    logic             ovf_now;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] final_res;

    // Operands shift right by one chunk per cycle, so the active chunk is
    // always the low CHUNK bits; no variable part-select is needed.
    assign slice_a   = a_q[CHUNK-1:0];
    assign slice_b   = b_q[CHUNK-1:0];
    assign slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + (CHUNK+1)'(carry_q);

    // Carry into the slice MSB recovered from the sum bit: s = a ^ b ^ cin.
    // Only meaningful on the final chunk, where the slice MSB is bit WIDTH-1.
    assign msb_cin = slice_sum[CHUNK-1] ^ slice_a[CHUNK-1] ^ slice_b[CHUNK-1];
    assign ovf_now = msb_cin ^ slice_sum[CHUNK];

    // Sum register fills from the top; after N shifts the LSB chunk lands at bit 0.
    assign sum_next = (sum_q >> CHUNK) | (WIDTH'(slice_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

`ifdef ADDSUB_SAT_EN
    // Overflow direction follows the sign of A: the (possibly inverted) B always has
    // the opposite sign to the wrapped result when overflow occurs.
    assign final_res = !ovf_now  ? sum_next :
                       a_sign_q  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                   {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign final_res = sum_next;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_sign_d = a_sign_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Subtraction as a + ~b + 1: invert b here, seed carry with mode.
                    a_d      = a;
                    b_d      = b ^ {WIDTH{mode}};
                    carry_d  = mode;
                    a_sign_d = a[WIDTH-1];
                    cnt_d    = '0;
                    sum_d    = '0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = slice_sum[CHUNK];
                sum_d   = sum_next;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    result_d = final_res;
                    cout_d   = slice_sum[CHUNK];
                    ovf_d    = ovf_now;
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sign_q <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_sign_q <= a_sign_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q == S_BUSY);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_addsub_seq.sv
// tb/tb_addsub_seq.sv - self-checking bench for addsub_seq (WIDTH=16, CHUNK=4)
module tb_addsub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    logic [15:0] last_res;

    addsub_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .mode   (mode),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [15:0] pick(input logic [15:0] wrap_v, input logic [15:0] sat_v);
`ifdef ADDSUB_SAT_EN
        return sat_v;
`else
        return wrap_v;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One operation: start pulse, count busy cycles, check done pulse, outputs, and
    // that result never shows intermediate slices. inject pulses start during BUSY/DONE.
    task automatic run_op(input string nm, input logic m, input logic [15:0] va,
                          input logic [15:0] vb, input logic [15:0] er, input logic eco,
                          input logic eov, input logic inject);
        int  busy_n;
        bit  got;
        bit  held;
        @(negedge clk);
        start = 1'b1; a = va; b = vb; mode = m;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom);
        busy_n = 0; got = 0; held = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (done) begin
                got = 1;
            end else begin
                if (busy) busy_n++;
                if (result !== last_res) held = 0;
                if (inject) begin start = 1'b1; a = 16'h1111; b = 16'h1111; mode = 1'b0; end
                @(negedge clk);
            end
        end
        chk({nm, " done_seen"}, 32'(got), 32'd1);
        chk({nm, " busy_cycles"}, 32'(busy_n), 32'd4);
        chk({nm, " result_held"}, 32'(held), 32'd1);
        chk({nm, " result"}, 32'(result), 32'(er));
        chk({nm, " cout"}, 32'(cout), 32'(eco));
        chk({nm, " ovf"}, 32'(ovf), 32'(eov));
        chk({nm, " busy_in_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk({nm, " done_pulse_end"}, 32'({busy, done}), 32'd0);
        last_res = er;
        if (inject) begin
            got = 0;
            for (int i = 0; i < 8; i++) begin
                if (busy || done) got = 1;
                @(negedge clk);
            end
            chk({nm, " no_extra_op"}, 32'(got), 32'd0);
            chk({nm, " result_after"}, 32'(result), 32'(er));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 16'h0006, 16'h0003, 16'h0003, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 16'h0008, 16'h0009, 16'hFFFF, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 16'h7FFF, 16'h0001, pick(16'h8000, 16'h7FFF), 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 16'h8000, 16'h0001, pick(16'h7FFF, 16'h8000), 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 16'h000F, 16'h0001, 16'h0010, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 16'h8000, 16'h8000, pick(16'h0000, 16'h8000), 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 16'h5555, 16'h5555, 16'h0000, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 16'h0000, 16'h8000, pick(16'h8000, 16'h7FFF), 1'b0, 1'b1};
        vecs[10] = '{1'b0, 16'h4000, 16'h4000, pick(16'h8000, 16'h7FFF), 1'b0, 1'b1};
        vecs[11] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; mode = 1'b0;
        last_res = 16'h0000;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset outputs", 32'({result, cout, ovf}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle no start", 32'({busy, done}), 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].co, vecs[i].ov, 1'b0);
        end

        run_op("ignore_start", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);

        run_op("pre_reset", 1'b1, 16'h8000, 16'h0001, pick(16'h7FFF, 16'h8000), 1'b1, 1'b1, 1'b0);

        @(negedge clk);
        start = 1'b1; a = 16'h1234; b = 16'h1111; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort outputs", 32'({result, cout, ovf}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_res = 16'h0000;
        @(negedge clk);
        chk("post abort idle", 32'({busy, done}), 32'd0);
        run_op("fresh", 1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
